fifo_datapath: RTL and testbench
================================

FIFO_DATAPATH -- requirements
Module: fifo_datapath

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 8, power of two >=2, SHALL set the number of storage entries.
REQ-003 Parameter ADDR_WIDTH, default 3, SHALL equal log2(DEPTH) and size the pointers.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 din  input  DATA_WIDTH  write data.
REQ-007 ld1  input  1  controller write-pointer advance strobe.
REQ-008 ld2  input  1  controller storage-write strobe.
REQ-009 ld3  input  1  controller read strobe (output-register load plus read-pointer advance).
REQ-010 dout  output  DATA_WIDTH  registered read data.
REQ-011 empty  output  1  high when count==0, to the controller.
REQ-012 full  output  1  high when count==DEPTH, to the controller.
REQ-013 count  output  ADDR_WIDTH+1  current occupancy.

Function
REQ-014 Internal state SHALL be DEPTH x DATA_WIDTH storage, wptr and rptr (ADDR_WIDTH bits each), and count (ADDR_WIDTH+1 bits).
REQ-015 rd_acc SHALL equal ld3 & ~empty.
REQ-016 wr_acc SHALL equal ld1 & ld2 & (~full | rd_acc).
REQ-017 ld1 or ld2 asserted alone SHALL have no effect.
REQ-018 On a clock edge with wr_acc, din SHALL be written to mem[wptr], and wptr SHALL increment modulo DEPTH (natural wrap from DEPTH-1 to 0).
REQ-019 On a clock edge with rd_acc, dout SHALL load mem[rptr], and rptr SHALL increment modulo DEPTH.
REQ-020 Write-to-read latency SHALL be 1 cycle: data written at edge N is readable at edge N+1 or later, and appears on dout one edge after its accepted ld3.
REQ-021 When rd_acc and wr_acc are both set in one cycle with rptr==wptr (full), dout SHALL load the old entry before it is overwritten.
REQ-022 Count update rules:
- wr_acc only: count+1.
- rd_acc only: count-1.
- both or neither: count unchanged.
REQ-023 ld3 while empty SHALL be ignored: dout holds, rptr and count unchanged.
REQ-024 ld3 with ld1 & ld2 while empty SHALL perform only the write; there is no bypass to dout.
REQ-025 ld1 & ld2 while full without ld3 SHALL be ignored: storage, wptr and count unchanged.
REQ-026 ld1 & ld2 & ld3 while full SHALL perform both the read and the write, leaving count at DEPTH.
REQ-027 empty and full SHALL be decoded combinationally from registered count only, never from ld inputs.
REQ-028 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-029 Asserting rst SHALL immediately clear wptr, rptr, count and dout to 0, giving empty=1, full=0.
REQ-030 Storage contents SHALL NOT be reset.
REQ-031 rst asserted mid-operation SHALL discard all stored entries; the first write after release SHALL land in entry 0.

Configuration
REQ-032 With macro FIFO_ERR_FLAGS_EN defined, the block SHALL add outputs overflow and underflow (1 bit each, reset 0) and input err_clr (1 bit).
REQ-033 With FIFO_ERR_FLAGS_EN defined:
- overflow SHALL set sticky on ld1 & ld2 & full & ~ld3.
- underflow SHALL set sticky on ld3 & empty.
- both SHALL clear on err_clr; a set condition in the same cycle as err_clr wins.
REQ-034 Without FIFO_ERR_FLAGS_EN, those ports and flag registers SHALL NOT exist, and all other behaviour is unchanged.

Verification
REQ-035 Reset, then write 0x11..0x88 (8 cycles of ld1 & ld2) -> full=1, count=8, empty=0.
REQ-036 From full, 8 cycles of ld3 -> dout sequence 0x11..0x88, then empty=1, count=0.
REQ-037 Write 10 then read 10, interleaved to cross the pointer wrap -> data order preserved, no loss.
REQ-038 Full, then ld1 & ld2 & ld3 with din=0x99 -> dout=oldest entry, count stays 8, 0x99 is read last.
REQ-039 Empty, then ld3 -> dout unchanged, count 0; with FIFO_ERR_FLAGS_EN, underflow=1 until err_clr.
REQ-040 rst pulsed mid-stream at count=5 -> count=0 and empty=1 at once; the next write and read returns the new data.

Source files
------------

// File: rtl/fifo_datapath.sv
// fifo_datapath: FIFO storage, pointers, occupancy count and registered
// read port, driven by an external controller through ld1/ld2/ld3 strobes.
// Optional sticky overflow/underflow flags with err_clr are built when the
// macro FIFO_ERR_FLAGS_EN is defined; the default build omits them.
module fifo_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ld1,
  input  logic                  ld2,
  input  logic                  ld3,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_acc, wr_acc;

  // Flags decode from the registered count only.
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign count = count_q;
  assign dout  = dout_q;

  // Accept decisions and next-state values for pointers, count and dout.
  always_comb begin
    rd_acc  = ld3 & ~empty;
    // A concurrent read frees the slot, so a write is accepted even when full.
    wr_acc  = ld1 & ld2 & (~full | rd_acc);
    wptr_d  = wr_acc ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = rd_acc ? rptr_q + PTR_ONE : rptr_q;
    // When full with both accepted, rptr==wptr: mem_q still holds the old
    // entry here because the storage write lands at the same edge.
    dout_d  = rd_acc ? mem_q[rptr_q] : dout_q;
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= din;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Sticky error flags; a new error in the err_clr cycle keeps the flag set.
  always_comb begin
    overflow_d  = (ld1 & ld2 & full & ~ld3) | (overflow_q & ~err_clr);
    underflow_d = (ld3 & empty) | (underflow_q & ~err_clr);
  end

  // Error flag registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_datapath.sv
// Self-checking bench for fifo_datapath: queue-based reference model,
// per-cycle comparator on the falling edge, directed scenarios with literal
// expectations, then a long randomized phase.
module tb_fifo_datapath;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          ld1 = 1'b0, ld2 = 1'b0, ld3 = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, full;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          err_clr = 1'b0;
  logic          overflow, underflow;
  logic          ovf_m = 1'b0, unf_m = 1'b0;
`endif

  fifo_datapath #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .ld1(ld1), .ld2(ld2), .ld3(ld3),
    .dout(dout), .empty(empty), .full(full), .count(count)
`ifdef FIFO_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the last word read out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] dout_m = '0;
  logic          chk_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_count", 32'(count), 32'(q.size()));
      check("cyc_empty", 32'(empty), 32'(q.size() == 0));
      check("cyc_full",  32'(full),  32'(q.size() == DP));
      check("cyc_dout",  32'(dout),  32'(dout_m));
`ifdef FIFO_ERR_FLAGS_EN
      check("cyc_overflow",  32'(overflow),  32'(ovf_m));
      check("cyc_underflow", 32'(underflow), 32'(unf_m));
`endif
    end
  end

  // One clock: drive strobes, take the edge, advance the model, settle.
  task automatic cyc(input logic [DW-1:0] d, input logic l1, input logic l2,
                     input logic l3, input logic clr = 1'b0);
    bit was_full, was_empty, rd, wr;
    din = d; ld1 = l1; ld2 = l2; ld3 = l3;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    @(posedge clk);
    was_full  = (q.size() == DP);
    was_empty = (q.size() == 0);
    rd = l3 && !was_empty;
    wr = l1 && l2 && (!was_full || rd);
    if (rd) dout_m = q.pop_front();
    if (wr) q.push_back(d);
`ifdef FIFO_ERR_FLAGS_EN
    ovf_m = (l1 && l2 && was_full && !l3) || (ovf_m && !clr);
    unf_m = (l3 && was_empty) || (unf_m && !clr);
`else
    if (clr) checks = checks + 0;
`endif
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_dout",  32'(dout),  32'd0);
    q.delete();
    dout_m = '0;
`ifdef FIFO_ERR_FLAGS_EN
    ovf_m = 1'b0; unf_m = 1'b0;
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int p_w, p_r;
    logic [DW-1:0] v;
    ld1 = 0; ld2 = 0; ld3 = 0;
    @(posedge clk); #1;
    do_reset();
    chk_en = 1'b1;

    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++) begin
      v = 8'(i * 17);
      cyc(v, 1, 1, 0);
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd8);
    check("fill_empty", 32'(empty), 32'd0);

    // Drain: oldest first.
    for (int i = 1; i <= 8; i++) begin
      cyc('0, 0, 0, 1);
      check("drain_dout", 32'(dout), 32'(i * 17));
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    // Read while empty is ignored.
    cyc('0, 0, 0, 1);
    check("emptyrd_dout",  32'(dout),  32'h88);
    check("emptyrd_count", 32'(count), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    check("underflow_set", 32'(underflow), 32'd1);
    cyc('0, 0, 0, 0);
    check("underflow_hold", 32'(underflow), 32'd1);
    cyc('0, 0, 0, 0, 1);
    check("underflow_clr", 32'(underflow), 32'd0);
`endif

    // Single strobes alone do nothing.
    cyc(8'h55, 1, 0, 0);
    cyc(8'h56, 0, 1, 0);
    check("lone_strobe_count", 32'(count), 32'd0);

    // Write-and-read while empty: write only, no bypass.
    cyc(8'h5A, 1, 1, 1);
    check("emptywr_count", 32'(count), 32'd1);
    check("emptywr_dout",  32'(dout),  32'h88);
    cyc('0, 0, 0, 1);
    check("emptywr_read", 32'(dout), 32'h5A);

    // Fill with 0xF0..0xF7, then write while full is ignored.
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'hF0 + i);
      cyc(v, 1, 1, 0);
    end
    cyc(8'hEE, 1, 1, 0);
    check("ovf_count", 32'(count), 32'd8);
`ifdef FIFO_ERR_FLAGS_EN
    check("overflow_set", 32'(overflow), 32'd1);
    cyc(8'hEE, 1, 1, 0, 1);
    check("overflow_setwins", 32'(overflow), 32'd1);
    cyc('0, 0, 0, 0, 1);
    check("overflow_clr", 32'(overflow), 32'd0);
`endif

    // Simultaneous read+write at full.
    cyc(8'h99, 1, 1, 1);
    check("fullrw_dout",  32'(dout),  32'hF0);
    check("fullrw_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cyc('0, 0, 0, 1);
    check("fullrw_last", 32'(dout), 32'h99);

    // Ten through, interleaved so pointers wrap.
    for (int i = 0; i < 10; i++) begin
      v = 8'(8'h30 + i);
      cyc(v, 1, 1, (i >= 3));
    end
    for (int i = 0; i < 3; i++) cyc('0, 0, 0, 1);
    check("wrap_last",  32'(dout),  32'h39);
    check("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-stream at count=5.
    for (int i = 0; i < 5; i++) cyc(8'(8'h60 + i), 1, 1, 0);
    check("pre_rst_count", 32'(count), 32'd5);
    chk_en = 1'b0;
    do_reset();
    chk_en = 1'b1;
    cyc(8'hA5, 1, 1, 0);
    cyc('0, 0, 0, 1);
    check("post_rst_data",  32'(dout),  32'hA5);
    check("post_rst_empty", 32'(empty), 32'd1);

    // Randomized phase with shifting write/read bias.
    for (int blk = 0; blk < 20; blk++) begin
      p_w = int'($urandom_range(20, 90));
      p_r = int'($urandom_range(20, 90));
      for (int i = 0; i < 150; i++) begin
        logic a, b, c, e;
        a = ($urandom_range(0, 99) < p_w);
        b = a ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
        c = ($urandom_range(0, 99) < p_r);
        e = ($urandom_range(0, 15) == 0);
        cyc(8'($urandom), a, b, c, e);
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
